uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial-to-byte UART receiver; the downstream partner of the team's UART transmitter.
- Samples the 8N1 line driven by the transmitter and returns received bytes to the MRAM statistics logic, e.g. for command/loopback checking.
- Presents each received byte on a valid/ack handshake.
- Flags framing errors and overruns.

Parameters:
- baud_rate, 24'd2000000, line bit rate in bits/s.
- clock_freq, 28'd100000000, uart_clock frequency in Hz.
- Derived localparams:
  - bit_period = clock_freq / baud_rate (default 50), 24-bit.
  - half_period = bit_period / 2 (default 25).
- Requirement: bit_period >= 8. Elaboration fails otherwise.

Ports:
- uart_clock  input  1  system clock, rising-edge.
- uart_reset  input  1  synchronous, active-high reset, sampled on the rising edge of uart_clock.
- uart_d_in  input  1  asynchronous serial line; idles high.
- uart_rx_ack  input  1  consumer accepts the current byte; one-cycle pulse or level.
- uart_d_out  output  8  last received byte, LSB = first data bit.
- uart_rx_valid  output  1  uart_d_out holds an unconsumed byte.
- uart_frame_error  output  1  one-cycle pulse: stop bit sampled low.
- uart_overrun  output  1  sticky: a byte arrived while uart_rx_valid was high.

Behaviour:
- Reset (uart_reset=1 at a clock edge):
  - state=Idle, uart_d_out=8'h00, uart_rx_valid=0, uart_frame_error=0, uart_overrun=0.
  - Clock counter=0, bit counter=0.
  - Synchronizer flops=2'b11.
  - Reset mid-frame abandons the frame and produces no valid.
- Input synchronization: two flops on uart_d_in, giving rxs. All decisions use rxs. Fixed 2-cycle input latency.
- State machine, one always_ff, states {Idle, Start_Check, Data_Bits, Stop_Bit, Wait_High}.
  - Idle: clk_count=0. rxs==0 -> Start_Check.
  - Start_Check: count to half_period-1.
    - At that point, rxs==0 -> Data_Bits, clk_count=0, bit_count=0.
    - rxs==1 -> false start (glitch), return to Idle with no flags.
  - Data_Bits: count to bit_period-1, then sample rxs into shift_reg[7]. Shift register shifts right, LSB first.
    - bit_count increments on each sample.
    - After the 8th sample -> Stop_Bit.
  - Stop_Bit: sample rxs after bit_period cycles.
    - rxs==1: load uart_d_out<=shift_reg and set uart_rx_valid, both visible the next cycle. Then -> Idle.
    - rxs==0: uart_frame_error=1 for exactly one cycle. uart_d_out and uart_rx_valid are unchanged. Then -> Wait_High.
  - Wait_High: stay until rxs==1, then -> Idle. A held-low line (break) cannot produce spurious frames.
  - default -> Idle.
- Timing and tolerance:
  - Sample points are mid-bit, relative to the detected falling edge.
  - Latency from the line's start edge to uart_rx_valid is about 2 + half_period + 9*bit_period + 1 cycles.
  - The companion transmitter holds each bit for bit_period+1 clocks. The receiver must decode this correctly: the worst-case drift of 9.5 clocks is below half_period.
  - Back-to-back frames with no idle gap must decode, because Idle is re-entered at mid-stop-bit.
- Handshake:
  - uart_rx_valid stays high until the clock edge where uart_rx_ack==1, then clears.
  - uart_rx_ack while uart_rx_valid==0 is ignored.
  - uart_rx_ack also clears uart_overrun.
- Simultaneous events:
  - New byte load and uart_rx_ack in the same cycle: the load wins. uart_rx_valid stays 1, uart_d_out takes the new byte, uart_overrun stays clear.
  - New byte load while uart_rx_valid==1 with no ack: uart_d_out is overwritten with the newest byte and uart_overrun is set.
- Counters: clk_count is 24-bit and bit_count is 4-bit. Both reset to 0 on every state entry and never wrap within a frame.

Test Plan:
- Reset, then a frame 0xA5 at bit_period=50 (start, 1,0,1,0,0,1,0,1, stop) -> uart_rx_valid rises once, uart_d_out=8'hA5. After uart_rx_ack pulse, uart_rx_valid=0 the next cycle.
- Line low for 10 cycles, then high -> no uart_rx_valid, no uart_frame_error. A following 0x3C frame decodes to 8'h3C.
- Frame 0x55 with stop bit driven low, line held low 200 cycles then released -> uart_frame_error one-cycle pulse, uart_rx_valid stays 0. A subsequent 0x81 frame decodes to 8'h81.
- Frames 0x12 then 0x34 with no ack -> uart_overrun=1, uart_d_out=8'h34, uart_rx_valid=1. A single ack clears both.
- Transmitter-timed stream (51 cycles/bit, no idle gap) carrying 0x00, 0xFF, 0x80, 0x01 with ack after each -> four valids, exact bytes, no flags.
- uart_reset asserted one cycle during bit 4 of frame 0xF0 -> no valid for that frame, all outputs at reset values. The next 0x0F frame decodes correctly.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ack byte handshake, framing error and overrun flags
module uart_rx #(
  parameter logic [23:0] baud_rate  = 24'd2000000,
  parameter logic [27:0] clock_freq = 28'd100000000
) (
  input  logic       uart_clock,
  input  logic       uart_reset,
  input  logic       uart_d_in,
  input  logic       uart_rx_ack,
  output logic [7:0] uart_d_out,
  output logic       uart_rx_valid,
  output logic       uart_frame_error,
  output logic       uart_overrun
);

  localparam logic [23:0] bit_period  = 24'(clock_freq / baud_rate);
  localparam logic [23:0] half_period = bit_period / 24'd2;

  // Too few clocks per bit leaves no usable mid-bit sample point.
  generate
    if (bit_period < 24'd8) begin : g_bad_bit_period
      $error("uart_rx: bit_period must be at least 8 clocks");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_CHECK,
    S_DATA_BITS,
    S_STOP_BIT,
    S_WAIT_HIGH
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  sync;
  logic        rxs;
  logic [23:0] clk_count;
  logic [3:0]  bit_count;
  logic [7:0]  shift_reg;
  logic        half_done;
  logic        bit_done;
  logic        sample_bit;
  logic        load_byte;
  logic        frame_bad;

  assign rxs       = sync[1];
  assign half_done = (clk_count == half_period - 24'd1);
  assign bit_done  = (clk_count == bit_period - 24'd1);

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge uart_clock) begin
    if (uart_reset) sync <= 2'b11;
    else            sync <= {sync[0], uart_d_in};
  end

  // State register.
  always_ff @(posedge uart_clock) begin
    if (uart_reset) state <= S_IDLE;
    else            state <= state_next;
  end

  // Next-state decode plus the per-cycle sample/load/error strobes.
  always_comb begin
    state_next = state;
    sample_bit = 1'b0;
    load_byte  = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) state_next = S_START_CHECK;
      end
      S_START_CHECK: begin
        // A line that is high again at mid-start was only a glitch.
        if (half_done) state_next = rxs ? S_IDLE : S_DATA_BITS;
      end
      S_DATA_BITS: begin
        if (bit_done) begin
          sample_bit = 1'b1;
          if (bit_count == 4'd7) state_next = S_STOP_BIT;
        end
      end
      S_STOP_BIT: begin
        // Leaving at mid-stop-bit lets a gapless next start edge be caught.
        if (bit_done) begin
          if (rxs) begin
            load_byte  = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Clock and bit counters restart on every state entry; clk_count also restarts after each data sample.
  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      clk_count <= 24'd0;
      bit_count <= 4'd0;
    end else if (state_next != state) begin
      clk_count <= 24'd0;
      bit_count <= 4'd0;
    end else if (sample_bit) begin
      clk_count <= 24'd0;
      bit_count <= bit_count + 4'd1;
    end else if (state == S_START_CHECK || state == S_DATA_BITS || state == S_STOP_BIT) begin
      clk_count <= clk_count + 24'd1;
    end
  end

  // Data bits arrive LSB first, so shift right and insert at the top.
  always_ff @(posedge uart_clock) begin
    if (uart_reset)      shift_reg <= 8'h00;
    else if (sample_bit) shift_reg <= {rxs, shift_reg[7:1]};
  end

  // Output byte, handshake and flags; a new byte load takes priority over ack.
  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      uart_d_out       <= 8'h00;
      uart_rx_valid    <= 1'b0;
      uart_frame_error <= 1'b0;
      uart_overrun     <= 1'b0;
    end else begin
      uart_frame_error <= frame_bad;
      if (load_byte) begin
        uart_d_out    <= shift_reg;
        uart_rx_valid <= 1'b1;
        if (uart_rx_valid && uart_rx_ack) uart_overrun <= 1'b0;
        else if (uart_rx_valid)           uart_overrun <= 1'b1;
      end else if (uart_rx_valid && uart_rx_ack) begin
        uart_rx_valid <= 1'b0;
        uart_overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  logic       uart_clock;
  logic       uart_reset;
  logic       uart_d_in;
  logic       uart_rx_ack;
  logic [7:0] uart_d_out;
  logic       uart_rx_valid;
  logic       uart_frame_error;
  logic       uart_overrun;

  int checks   = 0;
  int failures = 0;

  // Event counters maintained by the monitor; tests look at deltas.
  int   v_rises   = 0;
  int   fe_rises  = 0;
  int   fe_cycles = 0;
  logic prev_valid = 1'b0;
  logic prev_fe    = 1'b0;

  uart_rx #(
    .baud_rate (24'd2000000),
    .clock_freq(28'd100000000)
  ) dut (
    .uart_clock      (uart_clock),
    .uart_reset      (uart_reset),
    .uart_d_in       (uart_d_in),
    .uart_rx_ack     (uart_rx_ack),
    .uart_d_out      (uart_d_out),
    .uart_rx_valid   (uart_rx_valid),
    .uart_frame_error(uart_frame_error),
    .uart_overrun    (uart_overrun)
  );

  initial uart_clock = 1'b0;
  always #5 uart_clock = ~uart_clock;

  // Watch the outputs at the falling edge for valid rises and frame error pulses.
  always @(negedge uart_clock) begin
    prev_valid <= uart_rx_valid;
    prev_fe    <= uart_frame_error;
    if (uart_rx_valid === 1'b1 && prev_valid !== 1'b1) v_rises <= v_rises + 1;
    if (uart_frame_error === 1'b1 && prev_fe !== 1'b1) fe_rises <= fe_rises + 1;
    if (uart_frame_error === 1'b1) fe_cycles <= fe_cycles + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge uart_clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input int cyc, input logic stop_level);
    uart_d_in = 1'b0;
    repeat (cyc) @(negedge uart_clock);
    for (int i = 0; i < 8; i++) begin
      uart_d_in = b[i];
      repeat (cyc) @(negedge uart_clock);
    end
    uart_d_in = stop_level;
    repeat (cyc) @(negedge uart_clock);
    uart_d_in = 1'b1;
  endtask

  task automatic pulse_ack;
    uart_rx_ack = 1'b1;
    @(negedge uart_clock);
    uart_rx_ack = 1'b0;
  endtask

  task automatic test_reset;
    uart_reset  = 1'b1;
    uart_d_in   = 1'b1;
    uart_rx_ack = 1'b0;
    idle(3);
    uart_reset = 1'b0;
    idle(2);
    checks++; if (uart_d_out !== 8'h00) begin failures++; $display("FAIL reset_d_out got=%h exp=00", uart_d_out); end
    checks++; if (uart_rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", uart_rx_valid); end
    checks++; if (uart_frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", uart_frame_error); end
    checks++; if (uart_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", uart_overrun); end
  endtask

  task automatic test_basic;
    int v0, f0;
    v0 = v_rises; f0 = fe_rises;
    send_frame(8'hA5, 50, 1'b1);
    idle(20);
    checks++; if (v_rises - v0 !== 1) begin failures++; $display("FAIL basic_valid_rises got=%0d exp=1", v_rises - v0); end
    checks++; if (uart_rx_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", uart_rx_valid); end
    checks++; if (uart_d_out !== 8'hA5) begin failures++; $display("FAIL basic_d_out got=%h exp=a5", uart_d_out); end
    checks++; if (fe_rises - f0 !== 0) begin failures++; $display("FAIL basic_frame_error got=%0d exp=0", fe_rises - f0); end
    pulse_ack();
    checks++; if (uart_rx_valid !== 1'b0) begin failures++; $display("FAIL basic_ack_clear got=%b exp=0", uart_rx_valid); end
    idle(10);
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = v_rises; f0 = fe_rises;
    uart_d_in = 1'b0;
    idle(10);
    uart_d_in = 1'b1;
    idle(100);
    checks++; if (v_rises - v0 !== 0) begin failures++; $display("FAIL glitch_valid_rises got=%0d exp=0", v_rises - v0); end
    checks++; if (fe_rises - f0 !== 0) begin failures++; $display("FAIL glitch_frame_error got=%0d exp=0", fe_rises - f0); end
    send_frame(8'h3C, 50, 1'b1);
    idle(20);
    checks++; if (uart_rx_valid !== 1'b1) begin failures++; $display("FAIL glitch_next_valid got=%b exp=1", uart_rx_valid); end
    checks++; if (uart_d_out !== 8'h3C) begin failures++; $display("FAIL glitch_next_d_out got=%h exp=3c", uart_d_out); end
    pulse_ack();
    idle(10);
  endtask

  task automatic test_frame_error;
    int v0, f0, c0;
    v0 = v_rises; f0 = fe_rises; c0 = fe_cycles;
    send_frame(8'h55, 50, 1'b0);
    uart_d_in = 1'b0;
    idle(200);
    uart_d_in = 1'b1;
    idle(100);
    checks++; if (fe_rises - f0 !== 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", fe_rises - f0); end
    checks++; if (fe_cycles - c0 !== 1) begin failures++; $display("FAIL ferr_width got=%0d exp=1", fe_cycles - c0); end
    checks++; if (v_rises - v0 !== 0) begin failures++; $display("FAIL ferr_valid_rises got=%0d exp=0", v_rises - v0); end
    checks++; if (uart_rx_valid !== 1'b0) begin failures++; $display("FAIL ferr_valid got=%b exp=0", uart_rx_valid); end
    send_frame(8'h81, 50, 1'b1);
    idle(20);
    checks++; if (uart_rx_valid !== 1'b1) begin failures++; $display("FAIL ferr_next_valid got=%b exp=1", uart_rx_valid); end
    checks++; if (uart_d_out !== 8'h81) begin failures++; $display("FAIL ferr_next_d_out got=%h exp=81", uart_d_out); end
    pulse_ack();
    idle(10);
  endtask

  task automatic test_overrun;
    int v0;
    v0 = v_rises;
    send_frame(8'h12, 50, 1'b1);
    idle(20);
    checks++; if (uart_overrun !== 1'b0) begin failures++; $display("FAIL ovr_first got=%b exp=0", uart_overrun); end
    send_frame(8'h34, 50, 1'b1);
    idle(20);
    checks++; if (uart_overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", uart_overrun); end
    checks++; if (uart_d_out !== 8'h34) begin failures++; $display("FAIL ovr_d_out got=%h exp=34", uart_d_out); end
    checks++; if (uart_rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", uart_rx_valid); end
    checks++; if (v_rises - v0 !== 1) begin failures++; $display("FAIL ovr_valid_rises got=%0d exp=1", v_rises - v0); end
    pulse_ack();
    checks++; if (uart_rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_ack_valid got=%b exp=0", uart_rx_valid); end
    checks++; if (uart_overrun !== 1'b0) begin failures++; $display("FAIL ovr_ack_overrun got=%b exp=0", uart_overrun); end
    idle(10);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [4];
    logic [7:0] got_b [4];
    int v0, f0;
    logic saw_ovr;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h80; exp_b[3] = 8'h01;
    for (int i = 0; i < 4; i++) got_b[i] = 8'hxx;
    v0 = v_rises; f0 = fe_rises;
    saw_ovr = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_frame(exp_b[i], 51, 1'b1);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          int t;
          t = 0;
          while (uart_rx_valid !== 1'b1 && t < 2000) begin
            @(negedge uart_clock);
            t++;
          end
          if (uart_rx_valid === 1'b1) begin
            got_b[i] = uart_d_out;
            if (uart_overrun !== 1'b0) saw_ovr = 1'b1;
            pulse_ack();
          end
        end
      end
    join
    idle(20);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_b[i], exp_b[i]); end
    end
    checks++; if (v_rises - v0 !== 4) begin failures++; $display("FAIL b2b_valid_rises got=%0d exp=4", v_rises - v0); end
    checks++; if (fe_rises - f0 !== 0) begin failures++; $display("FAIL b2b_frame_error got=%0d exp=0", fe_rises - f0); end
    checks++; if (saw_ovr !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", saw_ovr); end
  endtask

  task automatic test_reset_midframe;
    int v0;
    v0 = v_rises;
    fork
      send_frame(8'hF0, 50, 1'b1);
      begin
        idle(275);
        uart_reset = 1'b1;
        idle(1);
        uart_reset = 1'b0;
      end
    join
    idle(50);
    checks++; if (v_rises - v0 !== 0) begin failures++; $display("FAIL rst_mid_valid_rises got=%0d exp=0", v_rises - v0); end
    checks++; if (uart_rx_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", uart_rx_valid); end
    checks++; if (uart_d_out !== 8'h00) begin failures++; $display("FAIL rst_mid_d_out got=%h exp=00", uart_d_out); end
    checks++; if (uart_frame_error !== 1'b0 || uart_overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b%b exp=00", uart_frame_error, uart_overrun); end
    send_frame(8'h0F, 50, 1'b1);
    idle(20);
    checks++; if (uart_rx_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_next_valid got=%b exp=1", uart_rx_valid); end
    checks++; if (uart_d_out !== 8'h0F) begin failures++; $display("FAIL rst_mid_next_d_out got=%h exp=0f", uart_d_out); end
    pulse_ack();
    idle(10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
